// File: rtl/alu_issue.sv
// RV32 OP/OP-IMM decode and issue stage with a one-entry skid buffer (optional M ops via ALU_ISSUE_M_EN).
// Latency: one cycle from upstream accept to o_valid when the output register is free or draining.
// Backpressure: the skid register absorbs one entry while i_ready is low; o_ready is the registered negation of skid-full.
module alu_issue #(
    parameter int ALU_OP_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [31:0]         i_instr,
    input  logic [31:0]         i_rs1_data,
    input  logic [31:0]         i_rs2_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic [31:0]         o_a,
    output logic [31:0]         o_b,
    output logic [4:0]          o_rd,
    output logic                o_illegal
);

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;

    localparam logic [ALU_OP_W-1:0] C_NOP = ALU_OP_W'(8'h00);
    localparam logic [ALU_OP_W-1:0] C_ADD = ALU_OP_W'(8'h11);
    localparam logic [ALU_OP_W-1:0] C_SUB = ALU_OP_W'(8'h12);
    localparam logic [ALU_OP_W-1:0] C_AND = ALU_OP_W'(8'h21);
    localparam logic [ALU_OP_W-1:0] C_OR  = ALU_OP_W'(8'h22);
    localparam logic [ALU_OP_W-1:0] C_XOR = ALU_OP_W'(8'h23);
    localparam logic [ALU_OP_W-1:0] C_SLT = ALU_OP_W'(8'h31);
    localparam logic [ALU_OP_W-1:0] C_SLL = ALU_OP_W'(8'h33);
    localparam logic [ALU_OP_W-1:0] C_SRL = ALU_OP_W'(8'h34);
    localparam logic [ALU_OP_W-1:0] C_SRA = ALU_OP_W'(8'h35);
`ifdef ALU_ISSUE_M_EN
    localparam logic [ALU_OP_W-1:0] C_MUL = ALU_OP_W'(8'h13);
    localparam logic [ALU_OP_W-1:0] C_DIV = ALU_OP_W'(8'h14);
    localparam logic [ALU_OP_W-1:0] C_MOD = ALU_OP_W'(8'h15);
`endif

    typedef struct packed {
        logic [ALU_OP_W-1:0] op;
        logic [31:0]         a;
        logic [31:0]         b;
        logic [4:0]          rd;
        logic                ill;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    // rs1/rs2 index fields arrive pre-read as i_rs*_data
    logic unused_rs_idx;
    assign unused_rs_idx = ^i_instr[19:15];

    logic [ALU_OP_W-1:0] d_op;
    logic                d_legal;
    logic                d_imm;
    logic                d_shamt;
    entry_t              dec;

    // Decode the incoming instruction into an issue entry; anything not matched stays illegal.
    always_comb begin
        d_op    = C_NOP;
        d_legal = 1'b0;
        d_imm   = 1'b0;
        d_shamt = 1'b0;
        if (opcode == OPC_OP) begin
            case (funct7)
                7'b0000000: begin
                    d_legal = 1'b1;
                    case (funct3)
                        3'b000:  d_op = C_ADD;
                        3'b001:  d_op = C_SLL;
                        3'b010:  d_op = C_SLT;
                        3'b100:  d_op = C_XOR;
                        3'b101:  d_op = C_SRL;
                        3'b110:  d_op = C_OR;
                        3'b111:  d_op = C_AND;
                        default: d_legal = 1'b0;
                    endcase
                end
                7'b0100000: begin
                    d_legal = 1'b1;
                    case (funct3)
                        3'b000:  d_op = C_SUB;
                        3'b101:  d_op = C_SRA;
                        default: d_legal = 1'b0;
                    endcase
                end
`ifdef ALU_ISSUE_M_EN
                7'b0000001: begin
                    d_legal = 1'b1;
                    case (funct3)
                        3'b000:  d_op = C_MUL;
                        3'b100:  d_op = C_DIV;
                        3'b110:  d_op = C_MOD;
                        default: d_legal = 1'b0;
                    endcase
                end
`endif
                default: d_legal = 1'b0;
            endcase
        end else if (opcode == OPC_IMM) begin
            d_legal = 1'b1;
            d_imm   = 1'b1;
            case (funct3)
                3'b000: d_op = C_ADD;
                3'b010: d_op = C_SLT;
                3'b100: d_op = C_XOR;
                3'b110: d_op = C_OR;
                3'b111: d_op = C_AND;
                3'b001: begin
                    d_shamt = 1'b1;
                    if (funct7 == 7'b0000000) d_op = C_SLL;
                    else                      d_legal = 1'b0;
                end
                3'b101: begin
                    d_shamt = 1'b1;
                    if (funct7 == 7'b0000000)      d_op = C_SRL;
                    else if (funct7 == 7'b0100000) d_op = C_SRA;
                    else                           d_legal = 1'b0;
                end
                default: d_legal = 1'b0;
            endcase
        end

        dec.rd  = i_instr[11:7];
        dec.ill = ~d_legal;
        if (d_legal) begin
            dec.op = d_op;
            dec.a  = i_rs1_data;
            if (d_shamt)    dec.b = {27'd0, i_instr[24:20]};
            else if (d_imm) dec.b = {{20{i_instr[31]}}, i_instr[31:20]};
            else            dec.b = i_rs2_data;
        end else begin
            dec.op = C_NOP;
            dec.a  = 32'd0;
            dec.b  = 32'd0;
        end
    end

    entry_t out_q;
    entry_t skid_q;
    logic   out_vld;
    logic   skid_full;
    logic   rdy_q;

    logic accept;
    logic drain;
    assign accept = i_valid & rdy_q;
    assign drain  = out_vld & i_ready;

    logic out_load_dec;
    logic out_load_skid;
    logic skid_load;
    logic out_vld_nxt;
    logic skid_full_nxt;

    // Steer each edge's accept/drain into the output and skid registers, preserving order.
    always_comb begin
        out_load_dec  = 1'b0;
        out_load_skid = 1'b0;
        skid_load     = 1'b0;
        out_vld_nxt   = out_vld;
        skid_full_nxt = skid_full;
        if (drain) begin
            if (skid_full) begin
                // rdy_q is low while the skid is full, so no accept can coincide here
                out_load_skid = 1'b1;
                skid_full_nxt = 1'b0;
            end else if (accept) begin
                out_load_dec = 1'b1;
            end else begin
                out_vld_nxt = 1'b0;
            end
        end else if (accept) begin
            if (out_vld) begin
                skid_load     = 1'b1;
                skid_full_nxt = 1'b1;
            end else begin
                out_load_dec = 1'b1;
                out_vld_nxt  = 1'b1;
            end
        end
    end

    // Control and data state; reset drops any in-flight entries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_vld   <= 1'b0;
            skid_full <= 1'b0;
            rdy_q     <= 1'b1;
            out_q     <= '0;
            skid_q    <= '0;
        end else begin
            out_vld   <= out_vld_nxt;
            skid_full <= skid_full_nxt;
            rdy_q     <= ~skid_full_nxt;
            if (out_load_skid)     out_q <= skid_q;
            else if (out_load_dec) out_q <= dec;
            if (skid_load)         skid_q <= dec;
        end
    end

    assign o_ready   = rdy_q;
    assign o_valid   = out_vld;
    assign o_alu_op  = out_q.op;
    assign o_a       = out_q.a;
    assign o_b       = out_q.b;
    assign o_rd      = out_q.rd;
    assign o_illegal = out_q.ill;

endmodule
